vga_ball_animator: RTL and testbench

Hardware motion engine feeding the VGA ball peripheral. It steps the ball position once per N video frames and bounces it off the screen edges. It then issues the resulting register writes as a zero-wait-state Avalon-MM write burst into the ball peripheral's slave port: radius at 0, x low/high at 3/4, y low/high at 5/6. It sits directly upstream of the ball peripheral, muxed with the HPS bridge, and takes the peripheral's own VGA_VS as its frame tick.

---
 rtl/vga_ball_animator.sv | 259 +++++++++++++++++++++++++
 tb/tb_vga_ball_animator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ball_animator.sv
// vga_ball_animator
//   Motion engine for the VGA ball peripheral. Once every FRAME_DIV frames
//   (frame tick = falling edge of vga_vs) it steps the ball centre by
//   speed_x/speed_y, bouncing off the screen edges, and then issues a
//   zero-wait-state Avalon-MM write burst into the ball peripheral:
//   radius @0, x low/high @3/4, y low/high @5/6.
//
//   Optional feature macro: VGA_ANIM_RADIUS_WR_EN
//     defined   : radius input used (saturated at 239), WR_R state present,
//                 five writes per step.
//     undefined : radius input ignored, radius fixed at RADIUS, four writes.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   enable              animation enable, sampled at the frame tick
//   vga_vs              VGA vertical sync from the peripheral (active low)
//   speed_x, speed_y    pixels per step (unsigned)
//   radius              requested radius
//   address, writedata,
//   write, chipselect   Avalon-MM master write port
//   busy                update/write sequence in progress
//   x, y                current ball centre
//
// FSM states
//   state    | meaning
//   S_IDLE   | waiting for a frame tick
//   S_UPDATE | compute new position/radius
//   S_WR_R   | write radius (address 0), feature builds only
//   S_WR_XL  | write x[4:0] (address 3)
//   S_WR_XH  | write x[9:5] (address 4)
//   S_WR_YL  | write y[4:0] (address 5)
//   S_WR_YH  | write y[9:5] (address 6)
module vga_ball_animator #(
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int X0        = 320,
  parameter int Y0        = 240,
  parameter int RADIUS    = 16,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vga_vs,
  input  logic [3:0] speed_x,
  input  logic [3:0] speed_y,
  input  logic [7:0] radius,
  output logic [2:0] address,
  output logic [7:0] writedata,
  output logic       write,
  output logic       chipselect,
  output logic       busy,
  output logic [9:0] x,
  output logic [9:0] y
);

`ifdef VGA_ANIM_RADIUS_WR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_WR_R, S_WR_XL, S_WR_XH, S_WR_YL, S_WR_YH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_WR_XL, S_WR_XH, S_WR_YL, S_WR_YH
  } state_t;
`endif

  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [10:0] H_SPAN   = 11'(H_MAX);
  localparam logic [10:0] V_SPAN   = 11'(V_MAX);

  state_t     state_q, state_d;
  logic       vs_q;
  logic [7:0] frm_cnt_q, frm_cnt_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 0 = right/down, 1 = left/up
  logic [7:0] eff_r_q, eff_r_d;
  logic [2:0] address_q, address_d;
  logic [7:0] writedata_q, writedata_d;
  logic       write_q, write_d;
  logic       busy_q, busy_d;

  logic        tick;
  logic [7:0]  eff_r_upd;
  logic [10:0] step_x, step_y;

  // One axis of motion. Returns {flip, new_pos}. Bounds are [r, span-1-r];
  // the sums are done at 11 bits so nothing wraps. A zero speed only clamps
  // an out-of-bounds position (e.g. after the radius grew) and never flips.
  function automatic logic [10:0] axis_step(
    input logic [9:0]  pos,
    input logic        dir,
    input logic [3:0]  spd,
    input logic [7:0]  r,
    input logic [10:0] span
  );
    logic [10:0] p, s, lo, hi;
    logic [9:0]  res;
    logic        flip;
    p    = {1'b0, pos};
    s    = {7'b0, spd};
    lo   = {3'b0, r};
    hi   = span - 11'd1 - lo;
    res  = pos;
    flip = 1'b0;
    if (spd == 4'd0) begin
      if (p > hi)      res = hi[9:0];
      else if (p < lo) res = lo[9:0];
    end else if (!dir) begin
      if (p + s >= hi) begin
        res  = hi[9:0];
        flip = 1'b1;
      end else begin
        res = pos + 10'(spd);
      end
    end else begin
      if (p < lo + s) begin
        res  = lo[9:0];
        flip = 1'b1;
      end else begin
        res = pos - 10'(spd);
      end
    end
    return {flip, res};
  endfunction

  assign tick = vs_q & ~vga_vs;

`ifdef VGA_ANIM_RADIUS_WR_EN
  assign eff_r_upd = (radius > 8'd239) ? 8'd239 : radius;
`else
  logic unused_radius;
  assign unused_radius = ^radius;
  assign eff_r_upd     = 8'(RADIUS);
`endif

  assign step_x = axis_step(x_q, dir_x_q, speed_x, eff_r_upd, H_SPAN);
  assign step_y = axis_step(y_q, dir_y_q, speed_y, eff_r_upd, V_SPAN);

  always_comb begin
    state_d     = state_q;
    frm_cnt_d   = frm_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    eff_r_d     = eff_r_q;
    address_d   = 3'd0;
    writedata_d = 8'd0;
    write_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ticks are only counted here; a tick during a sequence is dropped.
        if (tick && enable) begin
          if (frm_cnt_q == DIV_LAST) begin
            frm_cnt_d = 8'd0;
            state_d   = S_UPDATE;
          end else begin
            frm_cnt_d = frm_cnt_q + 8'd1;
          end
        end
      end
      S_UPDATE: begin
        eff_r_d = eff_r_upd;
        x_d     = step_x[9:0];
        dir_x_d = dir_x_q ^ step_x[10];
        y_d     = step_y[9:0];
        dir_y_d = dir_y_q ^ step_y[10];
`ifdef VGA_ANIM_RADIUS_WR_EN
        state_d = S_WR_R;
`else
        state_d = S_WR_XL;
`endif
      end
`ifdef VGA_ANIM_RADIUS_WR_EN
      S_WR_R:  state_d = S_WR_XL;
`endif
      S_WR_XL: state_d = S_WR_XH;
      S_WR_XH: state_d = S_WR_YL;
      S_WR_YL: state_d = S_WR_YH;
      S_WR_YH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being
    // entered, using the freshly computed position/radius.
    case (state_d)
`ifdef VGA_ANIM_RADIUS_WR_EN
      S_WR_R: begin
        address_d   = 3'd0;
        writedata_d = eff_r_d;
        write_d     = 1'b1;
      end
`endif
      S_WR_XL: begin
        address_d   = 3'd3;
        writedata_d = {3'b0, x_d[4:0]};
        write_d     = 1'b1;
      end
      S_WR_XH: begin
        address_d   = 3'd4;
        writedata_d = {3'b0, x_d[9:5]};
        write_d     = 1'b1;
      end
      S_WR_YL: begin
        address_d   = 3'd5;
        writedata_d = {3'b0, y_d[4:0]};
        write_d     = 1'b1;
      end
      S_WR_YH: begin
        address_d   = 3'd6;
        writedata_d = {3'b0, y_d[9:5]};
        write_d     = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      frm_cnt_q   <= 8'd0;
      x_q         <= 10'(X0);
      y_q         <= 10'(Y0);
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      eff_r_q     <= 8'(RADIUS);
      address_q   <= 3'd0;
      writedata_q <= 8'd0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vga_vs;
      frm_cnt_q   <= frm_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      eff_r_q     <= eff_r_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign write      = write_q;
  assign chipselect = write_q;
  assign busy       = busy_q;
  assign x          = x_q;
  assign y          = y_q;

endmodule

// File: tb/tb_vga_ball_animator.sv
// Testbench for vga_ball_animator. Works with or without
// VGA_ANIM_RADIUS_WR_EN; a second instance with FRAME_DIV=3 checks
// frame division.
module tb_vga_ball_animator;

`ifdef VGA_ANIM_RADIUS_WR_EN
  localparam bit RWR = 1'b1;
  localparam int L   = 5;
`else
  localparam bit RWR = 1'b0;
  localparam int L   = 4;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       vga_vs = 1'b1;
  logic [3:0] speed_x = 4'd0;
  logic [3:0] speed_y = 4'd0;
  logic [7:0] radius = 8'd16;

  logic [2:0] address, address3;
  logic [7:0] writedata, writedata3;
  logic       write, write3, chipselect, chipselect3, busy, busy3;
  logic [9:0] x, y, x3, y3;

  vga_ball_animator dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vga_vs(vga_vs),
    .speed_x(speed_x), .speed_y(speed_y), .radius(radius),
    .address(address), .writedata(writedata), .write(write),
    .chipselect(chipselect), .busy(busy), .x(x), .y(y)
  );

  vga_ball_animator #(.FRAME_DIV(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vga_vs(vga_vs),
    .speed_x(speed_x), .speed_y(speed_y), .radius(radius),
    .address(address3), .writedata(writedata3), .write(write3),
    .chipselect(chipselect3), .busy(busy3), .x(x3), .y(y3)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int w3_cnt = 0;

  always @(posedge clk) if (write3 && chipselect3) w3_cnt++;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ball position, direction (+1/-1), radius, burst.
  int mx, my, mdx, mdy, mr;
  int ea[5];
  int ed[5];

  task automatic model_reset();
    mx = 320; my = 240; mdx = 1; mdy = 1; mr = 16;
  endtask

  task automatic axis(inout int p, inout int d, input int s, input int r, input int span);
    int lo, hi;
    lo = r;
    hi = span - 1 - r;
    if (s == 0) begin
      if (p > hi) p = hi;
      else if (p < lo) p = lo;
    end else if (d > 0) begin
      if (p + s >= hi) begin p = hi; d = -1; end
      else p = p + s;
    end else begin
      if (p - s < lo) begin p = lo; d = 1; end
      else p = p - s;
    end
  endtask

  task automatic model_step();
    int k;
    if (RWR) mr = (int'(radius) > 239) ? 239 : int'(radius);
    else     mr = 16;
    axis(mx, mdx, int'(speed_x), mr, 640);
    axis(my, mdy, int'(speed_y), mr, 480);
    k = 0;
    if (RWR) begin ea[0] = 0; ed[0] = mr; k = 1; end
    ea[k]   = 3; ed[k]   = mx % 32;
    ea[k+1] = 4; ed[k+1] = mx / 32;
    ea[k+2] = 5; ed[k+2] = my % 32;
    ea[k+3] = 6; ed[k+3] = my / 32;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    vga_vs  = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One frame tick with the given enable; checks every cycle of the
  // following window. inj>0 injects a second tick (and drops enable)
  // in that cycle of the window.
  task automatic run_step(input bit en, input int inj);
    int ox, oy, eb, ew, exa, exd;
    ox = mx; oy = my;
    @(negedge clk);
    enable = en;
    vga_vs = 1'b0;
    if (en) model_step();
    for (int c = 1; c <= L + 4; c++) begin
      @(negedge clk);
      eb  = (en && c <= L + 1) ? 1 : 0;
      ew  = (en && c >= 2 && c <= L + 1) ? 1 : 0;
      exa = ew ? ea[c-2] : 0;
      exd = ew ? ed[c-2] : 0;
      check_eq("busy", int'(busy), eb);
      check_eq("write", int'(write), ew);
      check_eq("chipselect", int'(chipselect), ew);
      check_eq("address", int'(address), exa);
      check_eq("writedata", int'(writedata), exd);
      if (c == 1) begin
        check_eq("x_before", int'(x), ox);
        check_eq("y_before", int'(y), oy);
      end
      if (c == 2) begin
        check_eq("x_after", int'(x), mx);
        check_eq("y_after", int'(y), my);
      end
      if (c == 1) vga_vs = 1'b1;
      if (inj != 0 && c == inj) begin
        vga_vs = 1'b0;
        enable = 1'b0;
      end
    end
    vga_vs = 1'b1;
  endtask

  initial begin
    int w0;
    model_reset();
    do_reset();

    check_eq("rst_x", int'(x), 320);
    check_eq("rst_y", int'(y), 240);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_write", int'(write), 0);
    check_eq("rst_cs", int'(chipselect), 0);
    check_eq("rst_addr", int'(address), 0);
    check_eq("rst_wdata", int'(writedata), 0);

    // First step from reset.
    speed_x = 4'd3; speed_y = 4'd2; radius = 8'd16;
    run_step(1'b1, 0);
    check_eq("first_x", int'(x), 323);
    check_eq("first_y", int'(y), 242);

    // Right-wall bounce.
    do_reset();
    speed_x = 4'd15; speed_y = 4'd0;
    repeat (20) run_step(1'b1, 0);
    check_eq("x_pre_bounce", int'(x), 620);
    speed_x = 4'd5;
    run_step(1'b1, 0);
    check_eq("x_right_wall", int'(x), 623);
    run_step(1'b1, 0);
    check_eq("x_after_wall", int'(x), 618);

    // Bottom then top-wall bounce.
    do_reset();
    speed_x = 4'd0; speed_y = 4'd15;
    repeat (15) run_step(1'b1, 0);
    check_eq("y_bottom_wall", int'(y), 463);
    repeat (29) run_step(1'b1, 0);
    speed_y = 4'd10;
    run_step(1'b1, 0);
    check_eq("y_pre_top", int'(y), 18);
    speed_y = 4'd4;
    run_step(1'b1, 0);
    check_eq("y_top_wall", int'(y), 16);
    run_step(1'b1, 0);
    check_eq("y_after_top", int'(y), 20);

    // Frame division on the FRAME_DIV=3 instance.
    do_reset();
    speed_x = 4'd1; speed_y = 4'd1;
    for (int t = 1; t <= 6; t++) begin
      w0 = w3_cnt;
      run_step(1'b1, 0);
      check_eq("div3_en", w3_cnt - w0, (t % 3 == 0) ? L : 0);
    end
    for (int t = 1; t <= 6; t++) begin
      w0 = w3_cnt;
      run_step(1'b0, 0);
      check_eq("div3_dis", w3_cnt - w0, 0);
    end
    for (int t = 1; t <= 3; t++) begin
      w0 = w3_cnt;
      run_step(1'b1, 0);
      check_eq("div3_resume", w3_cnt - w0, (t == 3) ? L : 0);
    end

    // Tick plus enable drop during WR_XH: burst unchanged, no second one.
    speed_x = 4'd7; speed_y = 4'd9;
    run_step(1'b1, RWR ? 4 : 3);
    run_step(1'b0, 0);

    // Reset during WR_XL.
    @(negedge clk);
    enable = 1'b1;
    vga_vs = 1'b0;
    for (int c = 1; c <= (RWR ? 3 : 2); c++) begin
      @(negedge clk);
      if (c == 1) vga_vs = 1'b1;
    end
    check_eq("xl_write", int'(write), 1);
    check_eq("xl_addr", int'(address), 3);
    reset_n = 1'b0;
    #1;
    check_eq("abort_write", int'(write), 0);
    check_eq("abort_cs", int'(chipselect), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_x", int'(x), 320);
    check_eq("abort_y", int'(y), 240);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    speed_x = 4'd3; speed_y = 4'd2;
    run_step(1'b1, 0);
    check_eq("post_abort_x", int'(x), 323);
    check_eq("post_abort_y", int'(y), 242);

    // Randomized steps against the model.
    for (int i = 0; i < 40; i++) begin
      speed_x = 4'($urandom_range(0, 15));
      speed_y = 4'($urandom_range(0, 15));
      radius  = 8'($urandom_range(0, 255));
      run_step(($urandom_range(0, 3) != 0), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
